// File: rtl/mux_pipe_pkg.sv
// Shared types and constants for the operand-select stage and its N:1 mux.
package mux_pipe_pkg;
    localparam int ERR_CNT_W = 8;
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = 8'd255;

    // Widest data path the buffer entry can carry; instances use the low WIDTH bits.
    localparam int MAX_WIDTH = 64;

    typedef struct packed {
        logic [MAX_WIDTH-1:0] data;
        logic                 sel_err;
    } entry_t;

    function automatic int sel_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/mux_n_to_1.sv
// Combinational N:1 select; out-of-range selects yield zero data and err=1.
module mux_n_to_1 import mux_pipe_pkg::*; #(
    parameter  int WIDTH  = 32,
    parameter  int NUM_IN = 3,
    localparam int SEL_W  = sel_w(NUM_IN)
) (
    input  logic [SEL_W-1:0]        in_sel,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    output logic [WIDTH-1:0]        sel_data,
    output logic                    err
);
    always_comb begin
        sel_data = '0;
        err      = 1'b1;
        for (int k = 0; k < NUM_IN; k++) begin
            if (in_sel == SEL_W'(k)) begin
                sel_data = in_data[k*WIDTH +: WIDTH];
                err      = 1'b0;
            end
        end
    end
endmodule

// File: rtl/mux_sel_pipe.sv
// N:1 operand select registered behind a valid/ready 2-entry skid buffer.
// Define MUXP_ERR_CNT_EN to add the saturating illegal-select counter port err_count.
module mux_sel_pipe import mux_pipe_pkg::*; #(
    parameter  int WIDTH  = 32,
    parameter  int NUM_IN = 3,
    localparam int SEL_W  = sel_w(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_sel_err
`ifdef MUXP_ERR_CNT_EN
   ,output logic [ERR_CNT_W-1:0]    err_count
`endif
);
    logic [WIDTH-1:0] sel_data;
    logic             sel_err;
    entry_t           nxt, main_q, skid_q;
    logic             main_vld, skid_vld;
    logic             accept, drain;

    mux_n_to_1 #(.WIDTH(WIDTH), .NUM_IN(NUM_IN)) u_mux (
        .in_sel   (in_sel),
        .in_data  (in_data),
        .sel_data (sel_data),
        .err      (sel_err)
    );

    always_comb begin
        nxt                  = '0;
        nxt.data[WIDTH-1:0]  = sel_data;
        nxt.sel_err          = sel_err;
    end

    // Ready depends only on registered skid state, so there is no path from out_ready.
    assign in_ready = !skid_vld;
    assign accept   = in_valid && in_ready;
    assign drain    = main_vld && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
            main_q   <= '0;
            skid_q   <= '0;
        end else if (flush) begin
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
            main_q   <= '0;
            skid_q   <= '0;
        end else if (!main_vld || drain) begin
            if (skid_vld) begin
                main_q   <= skid_q;
                main_vld <= 1'b1;
                skid_vld <= 1'b0;
            end else if (accept) begin
                main_q   <= nxt;
                main_vld <= 1'b1;
            end else begin
                main_vld <= 1'b0;
            end
        end else if (accept) begin
            skid_q   <= nxt;
            skid_vld <= 1'b1;
        end
    end

    assign out_valid   = main_vld;
    assign out_data    = main_q.data[WIDTH-1:0];
    assign out_sel_err = main_q.sel_err;

    generate
        if (WIDTH < MAX_WIDTH) begin : g_pad
            logic unused_hi;
            assign unused_hi = ^main_q.data[MAX_WIDTH-1:WIDTH];
        end
    endgenerate

`ifdef MUXP_ERR_CNT_EN
    // Beats discarded by flush are not accepted, so they are not counted.
    always_ff @(posedge clk) begin
        if (!rst_n)
            err_count <= '0;
        else if (accept && !flush && sel_err && err_count != ERR_CNT_MAX)
            err_count <= err_count + 1'b1;
    end
`else
    // Counter absent; illegal selects remain visible per beat on out_sel_err.
`endif
endmodule

// File: tb/tb_mux_sel_pipe.sv
// Bench for mux_sel_pipe: directed checks on a 32-bit 3:1 instance, random sweep on an 8-bit 5:1 instance.
module tb_mux_sel_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        vld [2];
    logic        flush [2];
    logic        ordy [2];
    logic [2:0]  sel [2];
    logic [31:0] din [2][5];

    logic [95:0] in_data_a;
    logic [39:0] in_data_b;
    logic        rdy [2];
    logic        ov [2];
    logic        oe [2];
    logic [31:0] od_a;
    logic [7:0]  od_b;
`ifdef MUXP_ERR_CNT_EN
    logic [7:0]  ec [2];
`endif

    int checks = 0;
    int errors = 0;

    always_comb begin
        in_data_a = '0;
        in_data_b = '0;
        for (int k = 0; k < 3; k++) in_data_a[k*32 +: 32] = din[0][k];
        for (int k = 0; k < 5; k++) in_data_b[k*8 +: 8] = din[1][k][7:0];
    end

    mux_sel_pipe #(.WIDTH(32), .NUM_IN(3)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush[0]),
        .in_valid(vld[0]), .in_ready(rdy[0]), .in_sel(sel[0][1:0]), .in_data(in_data_a),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od_a), .out_sel_err(oe[0])
`ifdef MUXP_ERR_CNT_EN
       ,.err_count(ec[0])
`endif
    );

    mux_sel_pipe #(.WIDTH(8), .NUM_IN(5)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush[1]),
        .in_valid(vld[1]), .in_ready(rdy[1]), .in_sel(sel[1]), .in_data(in_data_b),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od_b), .out_sel_err(oe[1])
`ifdef MUXP_ERR_CNT_EN
       ,.err_count(ec[1])
`endif
    );

    // Reference: a FIFO holding at most two beats; ready whenever fewer than two are held.
    int          cnt [2] = '{0, 0};
    int          ecnt [2] = '{0, 0};
    logic [31:0] q_d [2][2];
    logic        q_e [2][2];
    bit          chk_en = 1'b0;

    function automatic int nin(input int m);
        return (m == 0) ? 3 : 5;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input int m);
        int s;
        bit acc;
        logic [31:0] mask;
        s    = (m == 0) ? int'(sel[m][1:0]) : int'(sel[m]);
        mask = (m == 0) ? 32'hFFFF_FFFF : 32'h0000_00FF;
        if (!rst_n) begin
            cnt[m]  = 0;
            ecnt[m] = 0;
            chk_en  = 1'b1;
        end else if (flush[m]) begin
            cnt[m] = 0;
        end else begin
            acc = vld[m] && (cnt[m] < 2);
            if (acc && s >= nin(m) && ecnt[m] < 255) ecnt[m]++;
            if (cnt[m] > 0 && ordy[m]) begin
                q_d[m][0] = q_d[m][1];
                q_e[m][0] = q_e[m][1];
                cnt[m]--;
            end
            if (acc) begin
                q_d[m][cnt[m]] = (s < nin(m)) ? (din[m][s] & mask) : 32'd0;
                q_e[m][cnt[m]] = (s >= nin(m));
                cnt[m]++;
            end
        end
    endtask

    always @(posedge clk) begin
        model_step(0);
        model_step(1);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int m = 0; m < 2; m++) begin
                chk($sformatf("in_ready[%0d]", m), 32'(rdy[m]), 32'(cnt[m] < 2));
                chk($sformatf("out_valid[%0d]", m), 32'(ov[m]), 32'(cnt[m] > 0));
                if (cnt[m] > 0) begin
                    chk($sformatf("out_data[%0d]", m), (m == 0) ? od_a : 32'(od_b), q_d[m][0]);
                    chk($sformatf("out_sel_err[%0d]", m), 32'(oe[m]), 32'(q_e[m][0]));
                end
`ifdef MUXP_ERR_CNT_EN
                chk($sformatf("err_count[%0d]", m), 32'(ec[m]), 32'(ecnt[m]));
`endif
            end
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic lit_a(input string name, input logic v, input logic [31:0] d, input logic e, input logic r);
        chk({name, ".out_valid"}, 32'(ov[0]), 32'(v));
        if (v) begin
            chk({name, ".out_data"}, od_a, d);
            chk({name, ".out_sel_err"}, 32'(oe[0]), 32'(e));
        end
        chk({name, ".in_ready"}, 32'(rdy[0]), 32'(r));
    endtask

    task automatic lit_ec(input string name, input int exp);
`ifdef MUXP_ERR_CNT_EN
        chk({name, ".err_count"}, 32'(ec[0]), 32'(exp));
`else
        if (exp < 0) $display("unused %s", name);
`endif
    endtask

    initial begin
        for (int m = 0; m < 2; m++) begin
            vld[m] = 1'b1; flush[m] = 1'b0; ordy[m] = 1'b1; sel[m] = '0;
            for (int k = 0; k < 5; k++) din[m][k] = '0;
        end
        din[0][0] = 32'h11; din[0][1] = 32'h22; din[0][2] = 32'h33;
        cyc(); cyc();
        chk("reset.out_data", od_a, 32'd0);
        chk("reset.out_sel_err", 32'(oe[0]), 32'd0);
        lit_a("reset", 1'b0, 32'd0, 1'b0, 1'b1);
        lit_ec("reset", 0);
        rst_n = 1'b1;
        fork
            begin : directed_a
                vld[0] = 1'b0; cyc();
                // back-to-back streaming
                vld[0] = 1'b1; sel[0] = 3'd0; cyc(); lit_a("stream0", 1'b1, 32'h11, 1'b0, 1'b1);
                sel[0] = 3'd1; cyc(); lit_a("stream1", 1'b1, 32'h22, 1'b0, 1'b1);
                sel[0] = 3'd2; cyc(); lit_a("stream2", 1'b1, 32'h33, 1'b0, 1'b1);
                vld[0] = 1'b0; cyc(); lit_a("stream_idle", 1'b0, 32'd0, 1'b0, 1'b1);
                // stall fills main then skid
                ordy[0] = 1'b0; vld[0] = 1'b1; sel[0] = 3'd1; cyc(); lit_a("stall1", 1'b1, 32'h22, 1'b0, 1'b1);
                sel[0] = 3'd2; cyc(); lit_a("stall2", 1'b1, 32'h22, 1'b0, 1'b0);
                vld[0] = 1'b0; cyc(); lit_a("stall_hold", 1'b1, 32'h22, 1'b0, 1'b0);
                ordy[0] = 1'b1; cyc(); lit_a("unstall", 1'b1, 32'h33, 1'b0, 1'b1);
                cyc(); lit_a("drained", 1'b0, 32'd0, 1'b0, 1'b1);
                // illegal select
                vld[0] = 1'b1; sel[0] = 3'd3; cyc(); lit_a("illegal", 1'b1, 32'd0, 1'b1, 1'b1);
                lit_ec("illegal", 1);
                for (int i = 0; i < 299; i++) cyc();
                vld[0] = 1'b0; cyc(); lit_ec("saturate", 255);
                // flush with both entries full and a beat presented
                ordy[0] = 1'b0; vld[0] = 1'b1; sel[0] = 3'd0; cyc();
                sel[0] = 3'd1; cyc(); lit_a("pre_flush", 1'b1, 32'h11, 1'b0, 1'b0);
                flush[0] = 1'b1; sel[0] = 3'd2; cyc(); lit_a("flush", 1'b0, 32'd0, 1'b0, 1'b1);
                flush[0] = 1'b0; ordy[0] = 1'b1; sel[0] = 3'd0; cyc(); lit_a("post_flush", 1'b1, 32'h11, 1'b0, 1'b1);
                vld[0] = 1'b0; cyc(); lit_a("post_flush_idle", 1'b0, 32'd0, 1'b0, 1'b1);
                lit_ec("flush_keeps_count", 255);
                // reset mid-stall drops both beats
                ordy[0] = 1'b0; vld[0] = 1'b1; sel[0] = 3'd1; cyc();
                sel[0] = 3'd2; cyc();
                rst_n = 1'b0; vld[0] = 1'b0; cyc();
                rst_n = 1'b1; ordy[0] = 1'b1; cyc(); lit_a("reset_stall", 1'b0, 32'd0, 1'b0, 1'b1);
                lit_ec("reset_stall", 0);
                // random traffic on the 3:1 instance
                for (int i = 0; i < 3000; i++) begin
                    for (int k = 0; k < 3; k++) din[0][k] = $urandom;
                    vld[0]   = ($urandom_range(0, 3) != 0);
                    sel[0]   = 3'($urandom_range(0, 3));
                    ordy[0]  = ($urandom_range(0, 2) != 0);
                    flush[0] = ($urandom_range(0, 150) == 0);
                    cyc();
                end
            end
            begin : random_b
                for (int i = 0; i < 10000; i++) begin
                    for (int k = 0; k < 5; k++) din[1][k] = $urandom;
                    vld[1]   = ($urandom_range(0, 3) != 0);
                    sel[1]   = 3'($urandom_range(0, 7));
                    ordy[1]  = (i % 400 < 40) ? 1'b0 : ($urandom_range(0, 2) != 0);
                    flush[1] = ($urandom_range(0, 250) == 0);
                    cyc();
                end
            end
        join
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mux_sel_pipe.md
Name: mux_sel_pipe

Overview:
- Parametrised N:1 operand-select stage for the pipelined datapath; successor to the fixed 32-bit 3:1 forwarding mux.
- Selects one of NUM_IN flattened inputs, then registers the result behind a valid/ready handshake with a 2-entry skid buffer.
- Handles stall back-pressure, flush, and illegal selects, which return zero and raise a flag rather than driving Z.
- Sits between the hazard/forwarding logic and the EX-stage operand registers.

Parameters:
- WIDTH, 32, data width per input
- NUM_IN, 3, number of selectable inputs (2..16)
- SEL_W, $clog2(NUM_IN), select width (derived, not overridden)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- flush  in  1  synchronous clear of buffered data
- in_valid  in  1  input beat valid
- in_ready  out  1  stage can accept a beat
- in_sel  in  SEL_W  input index to forward
- in_data  in  NUM_IN*WIDTH  flattened inputs; input k occupies bits [k*WIDTH +: WIDTH]
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts
- out_data  out  WIDTH  selected data
- out_sel_err  out  1  beat was produced from an illegal select
- err_count  out  8  saturating illegal-select count (only with MUXP_ERR_CNT_EN)

Behaviour:
- Decided: one clock, clk; reset rst_n is synchronous and active-low.
- Reset (rst_n=0 at a clk edge): main and skid entries invalid; out_valid=0, out_data=0, out_sel_err=0, in_ready=1, err_count=0.
- Select: if in_sel<NUM_IN, sel_data=in_data[in_sel*WIDTH +: WIDTH] and err=0. Otherwise sel_data=0 and err=1. No X or Z is ever driven.
- Accept: a beat is accepted when in_valid && in_ready.
- Transfer: a beat leaves when out_valid && out_ready.
- Latency: an accepted beat appears on out_data in the next cycle (1-cycle latency) when the main entry is empty or draining.
- Storage: main entry drives the outputs; skid entry holds one beat.
- in_ready = !skid_valid. It is registered and independent of out_ready in the same cycle, so there is no combinational ready path.
- Main empty, or draining this cycle: an accepted beat loads main.
- Main full and stalled (out_ready=0): an accepted beat loads skid; in_ready drops next cycle.
- Main drains while skid is valid: skid moves to main; a simultaneous accept is impossible because in_ready=0.
- Ordering: strict FIFO; no beat is dropped or duplicated outside flush/reset.
- Stability: while out_valid && !out_ready, out_data and out_sel_err hold stable.
- Full-throughput: with out_ready held 1, one beat per cycle and skid is never used.
- Flush: both entries are invalidated at the edge. A beat presented during the flush cycle is discarded. Next cycle out_valid=0 and in_ready=1.
- Priority at a clk edge: rst_n over flush over normal operation.
- Reset or flush mid-stall drops both pending beats, with no partial output.

Optional Feature:
- Macro: MUXP_ERR_CNT_EN.
- Defined: err_count port exists. It increments by 1 for each accepted beat with an illegal select, saturates at 255, and clears only on reset (flush does not clear it).
- Undefined: the port and counter are absent. out_sel_err still operates.

Decomposition:
- Package mux_pipe_pkg holds:
  - clog2-based SEL_W helper function
  - ERR_CNT_W=8 and ERR_CNT_MAX=255
  - typedef of the buffer entry struct {data, sel_err}
- Sub-module mux_n_to_1 (purely combinational, parameters WIDTH and NUM_IN) produces sel_data and err.
- mux_sel_pipe instantiates mux_n_to_1 once and owns the skid buffer and counter.

Test Plan:
- Reset: assert rst_n=0 for 2 cycles with in_valid=1 -> out_valid=0, out_data=0, in_ready=1, err_count=0.
- Streaming: NUM_IN=3, inputs {A,B,C}={0x11,0x22,0x33}, in_sel 0,1,2 on consecutive cycles, out_ready=1 -> out_data 0x11,0x22,0x33 one cycle later each, back-to-back, in_ready constant 1.
- Stall/skid: out_ready=0 while sending beats sel=1 then sel=2 -> main holds 0x22; in_ready=0 after the 2nd accept. Raising out_ready -> 0x22 then 0x33 in order.
- Illegal select: in_sel=3 with NUM_IN=3 -> out_data=0, out_sel_err=1. With MUXP_ERR_CNT_EN, err_count=1; after 300 illegal beats it reads 255.
- Flush: flush with both entries full and in_valid=1 -> next cycle out_valid=0, in_ready=1; the subsequent beat sel=0 yields 0x11 only.
- Width/depth sweep: WIDTH=8, NUM_IN=5, random sel/valid/ready for 10k cycles -> scoreboard ordering match, zero drops, out_data stable during stalls.
